// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit: BIP I instruction fetch/sequencing stage (PC, IR, FETCH/LOAD/EXEC framing, HALT stop)
// Ports:
//   Clock, Reset_n     rising-edge clock, asynchronous active-low reset
//   Start              level start/restart request, honoured in IDLE and HALTED only
//   WrPc               decoder PC-advance strobe, honoured in EXEC only
//   IMemData           synchronous instruction memory read data (valid the cycle after IMemEn)
//   IMemEn, IMemAddr   instruction memory read enable and address (address always tracks Pc)
//   Pc                 program counter
//   Opcode, Operand    IR fields presented to decoder/datapath
//   InstrValid         high only in EXEC; qualifies decoder outputs
//   Halted             high in HALTED
module bip_fetch_unit #(
    parameter int unsigned PC_WIDTH    = 11,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic                   WrPc,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    output logic                   IMemEn,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    output logic [PC_WIDTH-1:0]    Pc,
    output logic [4:0]             Opcode,
    output logic [PC_WIDTH-1:0]    Operand,
    output logic                   InstrValid,
    output logic                   Halted
);
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_HALTED} state_t;
    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:  state_d = Start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                ir_d    = IMemData;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // HALT wins over WrPc so the halted PC points at the HALT itself
                state_d = (Opcode == 5'd0) ? S_HALTED : S_FETCH;
                pc_d    = (Opcode != 5'd0 && WrPc) ? pc_q + PC_WIDTH'(1) : pc_q;
            end
            S_HALTED: begin
                state_d = Start ? S_FETCH : S_HALTED;
                pc_d    = Start ? RST_PC : pc_q;
                ir_d    = Start ? '0 : ir_q;
            end
            default: state_d = S_IDLE;
        endcase
    end
    assign IMemEn     = (state_q == S_FETCH);
    assign IMemAddr   = pc_q;
    assign Pc         = pc_q;
    assign Opcode     = ir_q[INSTR_WIDTH-1 -: 5];
    assign Operand    = ir_q[PC_WIDTH-1:0];
    assign InstrValid = (state_q == S_EXEC);
    assign Halted     = (state_q == S_HALTED);
endmodule

// File: tb/tb_bip_fetch_unit.sv
// tb_bip_fetch_unit: scoreboard bench for bip_fetch_unit with a synchronous instruction memory model
module tb_bip_fetch_unit;
    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0, WrPc = 1'b0;
    logic [15:0] IMemData;
    logic        IMemEn, InstrValid, Halted;
    logic [10:0] IMemAddr, Pc, Operand;
    logic [4:0]  Opcode;
    logic        Start_w = 1'b0, WrPc_w = 1'b0;
    logic [15:0] IMemData_w = 16'h8001;
    logic        IMemEn_w, InstrValid_w, Halted_w;
    logic [10:0] IMemAddr_w, Pc_w, Operand_w;
    logic [4:0]  Opcode_w;
    logic [15:0] mem [0:2047];
    typedef struct {logic [10:0] pc; logic [15:0] ins;} exp_t;
    exp_t        eq[$];
    logic [10:0] fq[$];
    logic [15:0] exp_ir = 16'h0;
    logic        prev_iv = 1'b0;
    int          n_vec = 0, n_err = 0, iv_cnt = 0;
    always #5 clk = ~clk;
    bip_fetch_unit dut (
        .Clock(clk), .Reset_n(Reset_n), .Start(Start), .WrPc(WrPc), .IMemData(IMemData),
        .IMemEn(IMemEn), .IMemAddr(IMemAddr), .Pc(Pc), .Opcode(Opcode), .Operand(Operand),
        .InstrValid(InstrValid), .Halted(Halted));
    bip_fetch_unit #(.RESET_PC(2047)) dut_w (
        .Clock(clk), .Reset_n(Reset_n), .Start(Start_w), .WrPc(WrPc_w), .IMemData(IMemData_w),
        .IMemEn(IMemEn_w), .IMemAddr(IMemAddr_w), .Pc(Pc_w), .Opcode(Opcode_w), .Operand(Operand_w),
        .InstrValid(InstrValid_w), .Halted(Halted_w));
    always @(posedge clk) if (IMemEn) IMemData <= mem[IMemAddr];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) if (Reset_n) begin
        if (IMemEn) begin
            if (fq.size() == 0) check("fetch_unexpected", 1, 0);
            else check("fetch_addr", IMemAddr, fq.pop_front());
            check("fetch_opcode_stable", Opcode, exp_ir[15:11]);
        end
        if (InstrValid) begin
            exp_t e;
            iv_cnt++;
            check("iv_back_to_back", prev_iv, 0);
            check("iv_excl", {IMemEn, Halted}, 0);
            if (eq.size() == 0) check("exec_unexpected", 1, 0);
            else begin
                e = eq.pop_front();
                check("exec_opcode", Opcode, e.ins[15:11]);
                check("exec_operand", Operand, e.ins[10:0]);
                check("exec_pc", Pc, e.pc);
                exp_ir = e.ins;
            end
        end
        prev_iv = InstrValid;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Called with the DUT in FETCH (state entered at the preceding edge).
    task automatic do_instr(input logic [10:0] pc, input logic [15:0] ins, input logic wr);
        int n = 0;
        mem[pc] = ins;
        fq.push_back(pc);
        eq.push_back('{pc, ins});
        WrPc = wr;
        while (!InstrValid && n < 6) begin
            tick();
            n++;
        end
        check("exec_latency", n, 2);
        check("halted_in_exec", Halted, 0);
        tick();
    endtask
    task automatic restart();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        exp_ir = 16'h0;
        check("restart_opcode", Opcode, 0);
        check("restart_operand", Operand, 0);
        check("restart_pc", Pc, 0);
    endtask
    initial begin
        logic [10:0] pc;
        logic [15:0] ins;
        logic        wr;
        int          iv0, n;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        tick();
        tick();
        check("rst_signals", {IMemEn, InstrValid, Halted}, 0);
        check("rst_opcode", Opcode, 0);
        check("rst_operand", Operand, 0);
        check("rst_addr", IMemAddr, 0);
        check("rst_w_addr", IMemAddr_w, 2047);
        Reset_n = 1'b1;
        tick();
        tick();
        check("idle_no_fetch", IMemEn, 0);
        // wrap: RESET_PC=2047, nonzero opcode, WrPc=1 -> next fetch at 0
        WrPc_w = 1'b1;
        Start_w = 1'b1;
        tick();
        Start_w = 1'b0;
        check("wrap_first_fetch", {IMemEn_w, IMemAddr_w}, {1'b1, 11'd2047});
        n = 0;
        while (!InstrValid_w && n < 6) begin tick(); n++; end
        check("wrap_exec_pc", Pc_w, 2047);
        tick();
        check("wrap_next_fetch", {IMemEn_w, IMemAddr_w}, {1'b1, 11'd0});
        check("wrap_not_halted", Halted_w, 0);
        // straight-line program ending in HALT
        Start = 1'b1;
        tick();
        Start = 1'b0;
        do_instr(11'd0, {5'b01100, 11'd5}, 1'b1);
        do_instr(11'd1, {5'b10100, 11'd3}, 1'b1);
        do_instr(11'd2, {5'b00000, 11'd7}, 1'b1);
        check("halt_flags", {Halted, InstrValid, IMemEn}, 3'b100);
        check("halt_pc", Pc, 2);
        check("halt_ir_held", Operand, 7);
        tick();
        check("halt_stays", Halted, 1);
        // restart, Start held high through execution, WrPc=0 re-execution at PC 4
        Start = 1'b1;
        tick();
        exp_ir = 16'h0;
        check("restart_opcode", Opcode, 0);
        check("restart_operand", Operand, 0);
        check("restart_pc", Pc, 0);
        for (int i = 0; i < 4; i++) do_instr(11'(i), {5'(i + 1), 11'(i * 3)}, 1'b1);
        do_instr(11'd4, {5'b11111, 11'd9}, 1'b0);
        do_instr(11'd4, {5'b11111, 11'd9}, 1'b0);
        do_instr(11'd4, {5'b11111, 11'd9}, 1'b1);
        Start = 1'b0;
        do_instr(11'd5, 16'h0000, 1'b1);
        check("halt2_pc", {Halted, Pc}, {1'b1, 11'd5});
        // random nonzero instructions
        restart();
        iv0 = iv_cnt;
        pc = 11'd0;
        for (int i = 0; i < 100; i++) begin
            ins = {5'($urandom_range(31, 1)), 11'($urandom)};
            wr = 1'($urandom);
            do_instr(pc, ins, wr);
            if (wr) pc = pc + 11'd1;
        end
        do_instr(pc, 16'h0000, 1'b0);
        check("iv_count", iv_cnt - iv0, 101);
        check("halt3_pc", {Halted, Pc}, {1'b1, pc});
        // reset asserted mid-LOAD with all-ones memory data
        restart();
        mem[0] = 16'hFFFF;
        fq.push_back(11'd0);
        tick();
        Reset_n = 1'b0;
        #1;
        exp_ir = 16'h0;
        check("midrst_signals", {IMemEn, InstrValid, Halted}, 0);
        check("midrst_opcode", Opcode, 0);
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        check("postrst_opcode", Opcode, 0);
        check("postrst_operand", Operand, 0);
        check("postrst_idle", {IMemEn, InstrValid, Halted, Pc}, 0);
        check("sb_drained", fq.size() + eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
